// File: rtl/bitcoin_miner.sv
// Bitcoin proof-of-work engine.
// Receives an 80-byte header and a 28-byte target tail over an 8N1 UART.
// Searches nonces upward with double SHA-256 (one round per clock).
// Returns a 36-byte result frame {nonce, hash} over a second 8N1 UART line.
module bitcoin_miner #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  output logic serial_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {S_RECV, S_MID, S_HASH1, S_HASH2, S_CHECK, S_SEND} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Digest byte order -> Bitcoin display order (little-endian 256-bit number).
  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] y;
    for (int i = 0; i < 32; i++) y[8*i +: 8] = x[255-8*i -: 8];
    return y;
  endfunction

  // ---------------- UART receiver ----------------
  logic [1:0]       r_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_line;
  logic             w_rx_valid;

  assign w_rx_line  = r_sync[1];
  // A byte is delivered on the very edge that samples a high stop bit.
  assign w_rx_valid = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST) && w_rx_line;

  // Synchronize serial_in and deframe 8N1 bytes, sampling each bit at mid-bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      r_sync    <= {r_sync[0], serial_in};
      r_rx_prev <= w_rx_line;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !w_rx_line) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- Miner state ----------------
  state_t           r_state;
  logic [6:0]       r_byte_cnt;
  logic [863:0]     r_data;      // byte 0 ends at [863:856], T_low at [223:0]
  logic [31:0]      r_nonce;
  logic [6:0]       r_step;      // 0 load, 1..64 rounds, 65 feed-forward
  logic [31:0]      r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0]      r_w [16];    // W[t] .. W[t+15]
  logic [255:0]     r_hin;       // chaining value of the current compression
  logic [255:0]     r_mid;
  logic [255:0]     r_dig;
  logic [287:0]     r_tx_frame;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;    // 0 start, 1..8 data, 9 stop
  logic [5:0]       r_tx_idx;
  logic             r_serial;

  logic [511:0] w_blk;
  logic [255:0] w_chain;
  logic [5:0]   w_kidx;
  logic [31:0]  w_t1, w_t2, w_wnext;
  logic [255:0] w_ff, w_r, w_target;
  logic         w_hit;
  logic [7:0]   w_tx_byte;

  assign serial_out = r_serial;

  // Select the message block and chaining input for the active compression.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_blk   = '0;
    w_chain = SHA_IV;
    case (r_state)
      S_MID:   w_blk = r_data[863:352];
      S_HASH1: begin
        w_blk   = {r_data[351:256], r_nonce[7:0], r_nonce[15:8], r_nonce[23:16],
                   r_nonce[31:24], 8'h80, 312'h0, 64'd640};
        w_chain = r_mid;
      end
      S_HASH2: w_blk = {r_dig, 8'h80, 184'h0, 64'd256};
      default: ;
    endcase
  end

  assign w_kidx  = r_step[5:0] - 6'd1;
  assign w_t1    = r_h + bsig1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + K[w_kidx] + r_w[0];
  assign w_t2    = bsig0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
  assign w_wnext = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
  assign w_ff    = {r_a + r_hin[255:224], r_b + r_hin[223:192], r_c + r_hin[191:160],
                    r_d + r_hin[159:128], r_e + r_hin[127:96],  r_f + r_hin[95:64],
                    r_g + r_hin[63:32],   r_h + r_hin[31:0]};
  assign w_r       = bswap256(r_dig);
  assign w_target  = {32'h0, r_data[223:0]};
  assign w_hit     = (w_r <= w_target);
  assign w_tx_byte = r_tx_frame[287:280];

  // Main FSM: collect header, hash nonces, then serialize the result frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_RECV;
      r_byte_cnt <= '0;
      // NOTE: the wide data register and W window are cleared on reset too;
      // reset must leave no stale header or schedule words behind.
      r_data     <= '0;
      r_nonce    <= '0;
      r_step     <= '0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_hin      <= '0;
      r_mid      <= '0;
      r_dig      <= '0;
      r_tx_frame <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_idx   <= '0;
      r_serial   <= 1'b1;
    end else begin
      case (r_state)
        S_RECV: begin
          if (w_rx_valid) begin
            r_data <= {r_data[855:0], r_rx_shift};
            if (r_byte_cnt == 7'd107) begin
              r_byte_cnt <= '0;
              r_step     <= '0;
              r_state    <= S_MID;
            end else begin
              r_byte_cnt <= r_byte_cnt + 7'd1;
            end
          end
        end
        S_MID, S_HASH1, S_HASH2: begin
          if (r_step == 7'd0) begin
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_chain;
            r_hin <= w_chain;
            for (int i = 0; i < 16; i++) r_w[i] <= w_blk[511-32*i -: 32];
            // Start nonce is header bytes 76..79 read little-endian.
            if (r_state == S_MID)
              r_nonce <= {r_data[231:224], r_data[239:232], r_data[247:240], r_data[255:248]};
            r_step <= r_step + 7'd1;
          end else if (r_step <= 7'd64) begin
            r_h <= r_g;
            r_g <= r_f;
            r_f <= r_e;
            r_e <= r_d + w_t1;
            r_d <= r_c;
            r_c <= r_b;
            r_b <= r_a;
            r_a <= w_t1 + w_t2;
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wnext;
            r_step  <= r_step + 7'd1;
          end else begin
            r_step <= '0;
            case (r_state)
              S_MID:   begin r_mid <= w_ff; r_state <= S_HASH1; end
              S_HASH1: begin r_dig <= w_ff; r_state <= S_HASH2; end
              default: begin r_dig <= w_ff; r_state <= S_CHECK; end
            endcase
          end
        end
        S_CHECK: begin
          if (w_hit || (r_nonce == 32'hFFFF_FFFF)) begin
            r_tx_frame <= w_hit ? {r_nonce, w_r} : {32'hFFFF_FFFF, 256'h0};
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_idx   <= '0;
            r_serial   <= 1'b0;
            r_state    <= S_SEND;
          end else begin
            r_nonce <= r_nonce + 32'd1;
            r_state <= S_HASH1;
          end
        end
        S_SEND: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
              if (r_tx_idx == 6'd35) begin
                r_byte_cnt <= '0;
                r_state    <= S_RECV;
              end else begin
                r_tx_idx   <= r_tx_idx + 6'd1;
                r_tx_bit   <= '0;
                r_serial   <= 1'b0;
                r_tx_frame <= {r_tx_frame[279:0], 8'h00};
              end
            end else begin
              r_tx_bit <= r_tx_bit + 4'd1;
              r_serial <= (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_state <= S_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_miner.sv
// Directed bench for bitcoin_miner using the Bitcoin genesis block header.
// Expected frames are pushed to a scoreboard queue as each stream is sent
// and popped when the DUT transmits.
module tb_bitcoin_miner;

  localparam int CPB = 10;
  localparam logic [31:0]  GEN_NONCE  = 32'h7c2bac1d;
  localparam logic [255:0] GEN_R      =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [223:0] TLOW_DIFF1 = {16'hFFFF, 208'h0};

  logic clk = 1'b0;
  logic n_rst;
  logic serial_in;
  logic serial_out;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  logic [287:0] exp_q [$];
  logic [639:0] genesis;
  logic [287:0] frm, exp_frm;
  logic         fr_ok, got, quiet;
  int unsigned  t_last, t_tx, lat;

  bitcoin_miner #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .serial_in (serial_in),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  // Sends genesis header with the given start nonce, then T_low, as three
  // 36-byte packets with idle gaps; optionally injects a bad-stop byte.
  task automatic send_stream(input logic [31:0] nonce, input logic [223:0] tlow,
                             input int bad_at, output int unsigned last_start);
    logic [639:0] h;
    logic [863:0] s;
    h        = genesis;
    h[31:0]  = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    s        = {h, tlow};
    last_start = 0;
    for (int i = 0; i < 108; i++) begin
      if (i == 36 || i == 72) repeat (300) @(negedge clk);
      if (i == bad_at) begin
        send_byte(8'hA5, 1'b0);
        send_bit(1'b1);
      end
      if (i == 107) last_start = cyc;
      send_byte(s[863-8*i -: 8], 1'b1);
    end
  endtask

  // Waits (bounded) for a start bit, then samples 36 back-to-back bytes mid-bit.
  task automatic recv_frame(output logic [287:0] f, output logic ok,
                            output int unsigned t_start, output logic seen);
    logic [7:0] byt;
    f = '0; ok = 1'b1; seen = 1'b0; t_start = 0; byt = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (serial_out === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      t_start = cyc;
      for (int b = 0; b < 36; b++) begin
        for (int k = 0; k < 10; k++) begin
          repeat ((b == 0 && k == 0) ? 5 : 10) @(negedge clk);
          if (k == 0) begin
            if (serial_out !== 1'b0) ok = 1'b0;
          end else if (k == 9) begin
            if (serial_out !== 1'b1) ok = 1'b0;
          end else begin
            byt[k-1] = serial_out;
          end
        end
        f = {f[279:0], byt};
      end
    end
  endtask

  task automatic sb_pop(output logic [287:0] e);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 'x;
  endtask

  task automatic watch_quiet(input int n, output logic q);
    q = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (serial_out !== 1'b1) q = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_rst     = 1'b0;
    serial_in = 1'b1;
    genesis   = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

    // Reset state and long idle.
    repeat (5) @(negedge clk);
    check("rst_out", serial_out, 1'b1);
    n_rst = 1'b1;
    watch_quiet(10000, quiet);
    check("idle_quiet", quiet, 1'b1);

    // Genesis header starting at its winning nonce: one hash, found frame.
    // Stop bit of the last byte is sampled ~98 cycles after its start edge
    // (synchronizer + mid-bit), and TX starts 199 cycles after that.
    exp_q.push_back({GEN_NONCE, GEN_R});
    send_stream(GEN_NONCE, TLOW_DIFF1, -1, t_last);
    recv_frame(frm, fr_ok, t_tx, got);
    check("found_got", got, 1'b1);
    check("found_framing", fr_ok, 1'b1);
    sb_pop(exp_frm);
    check("found_frame", frm, exp_frm);
    lat = t_tx - t_last;
    check("found_latency", (lat >= 295 && lat <= 299), 1'b1);
    repeat (20) @(negedge clk);

    // Start three nonces early with a bad-stop byte mid-stream.
    exp_q.push_back({GEN_NONCE, GEN_R});
    send_stream(GEN_NONCE - 32'd3, TLOW_DIFF1, 50, t_last);
    recv_frame(frm, fr_ok, t_tx, got);
    check("search_got", got, 1'b1);
    check("search_framing", fr_ok, 1'b1);
    sb_pop(exp_frm);
    check("search_frame", frm, exp_frm);
    repeat (20) @(negedge clk);

    // Reset during HASH1 aborts the search; no frame follows.
    send_stream(GEN_NONCE, TLOW_DIFF1, -1, t_last);
    repeat (100) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("abort_rst_out", serial_out, 1'b1);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    watch_quiet(600, quiet);
    check("abort_quiet", quiet, 1'b1);

    // Fresh stream: last nonce with zero target -> exhausted frame.
    exp_q.push_back({32'hFFFF_FFFF, 256'h0});
    send_stream(32'hFFFF_FFFF, 224'h0, -1, t_last);
    recv_frame(frm, fr_ok, t_tx, got);
    check("exhaust_got", got, 1'b1);
    check("exhaust_framing", fr_ok, 1'b1);
    sb_pop(exp_frm);
    check("exhaust_frame", frm, exp_frm);
    lat = t_tx - t_last;
    check("exhaust_latency", (lat >= 295 && lat <= 299), 1'b1);

    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
